// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync pattern, then payload MSB-first, then an idle gap.
// A payload word is accepted through load/ready. x, done and the FSM state are
// flops, so the outputs have no combinational path from the inputs.
module sync_frame_tx #(
    parameter int                SYNC_W     = 5,
    parameter logic [SYNC_W-1:0] SYNC       = 5'b10011,
    parameter int                DATA_W     = 8,
    parameter int                GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              ready,
    output logic              x,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX = (SYNC_W > DATA_W)
                           ? ((SYNC_W > GAP_CYCLES) ? SYNC_W : GAP_CYCLES)
                           : ((DATA_W > GAP_CYCLES) ? DATA_W : GAP_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Reload values: the counter holds the number of bits still to follow
    // the one currently on x, so terminal count 0 means "last cycle here".
    localparam logic [CNT_W-1:0] SYNC_LD = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LD = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   dsh_q, dsh_d;
    logic [SYNC_W-1:0]   ssh_q, ssh_d;
    logic                x_q, x_d;
    logic                done_q, done_d;

    // Next-state, next-bit and shift-register updates for the frame sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dsh_d   = dsh_q;
        ssh_d   = ssh_q;
        x_d     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    dsh_d   = data_in;
                    // Sync MSB goes straight to x; the shifter holds the rest.
                    ssh_d   = SYNC << 1;
                    x_d     = SYNC[SYNC_W-1];
                    cnt_d   = SYNC_LD;
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (cnt_q == '0) begin
                    x_d     = dsh_q[DATA_W-1];
                    dsh_d   = dsh_q << 1;
                    cnt_d   = DATA_LD;
                    done_d  = (DATA_W == 1);
                    state_d = ST_DATA;
                end else begin
                    x_d   = ssh_q[SYNC_W-1];
                    ssh_d = ssh_q << 1;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    if (GAP_CYCLES > 0) begin
                        cnt_d   = GAP_LD;
                        state_d = ST_GAP;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    x_d    = dsh_q[DATA_W-1];
                    dsh_d  = dsh_q << 1;
                    cnt_d  = cnt_q - 1'b1;
                    // done rides with the last payload bit, which lands at count 0.
                    done_d = (cnt_q == CNT_W'(1));
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, shifters and output flops; reset aborts any frame at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dsh_q   <= '0;
            ssh_q   <= '0;
            x_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dsh_q   <= dsh_d;
            ssh_q   <= ssh_d;
            x_q     <= x_d;
            done_q  <= done_d;
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign busy  = ~ready;
    assign x     = x_q;
    assign done  = done_q;

endmodule

// File: doc/sync_frame_tx.md
Name: sync_frame_tx

Overview:
Serial frame transmitter for the 10011 sequence detector. It accepts a parallel payload word through a valid/ready handshake. It then emits on a single-bit line a fixed sync pattern (default 10011), followed by the payload MSB-first, followed by an idle gap. The block drives the serial input of the sequence-detector receive path and is used to generate detector stimulus in system benches.

Parameters:
SYNC_W, 5, sync pattern width in bits (>=1)
SYNC, 5'b10011, sync pattern; transmitted MSB (bit SYNC_W-1) first
DATA_W, 8, payload width in bits (>=1)
GAP_CYCLES, 2, forced idle (x=0) cycles after each frame before ready re-asserts (0 allowed)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
data_in  input  DATA_W  payload word; sampled only on an accepted load
load  input  1  payload valid; a transfer occurs when load && ready at a rising edge
ready  output  1  block can accept a payload (high only in IDLE)
x  output  1  serial line, registered
busy  output  1  high in SYNC, DATA and GAP states
done  output  1  one-cycle pulse, high while the last payload bit is on x

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, x=0, done=0, busy=0, shift register and counter cleared, ready=1 (decoded from IDLE). Reset mid-frame aborts the frame immediately; no partial bits follow. After release the block is in IDLE.
- Clock and reset: one clock domain. Asynchronous assert, synchronous-to-clk deassert is assumed from the reset synchroniser upstream.
- States: IDLE, SYNC, DATA, GAP. ready = (state==IDLE); busy = !ready.
- IDLE:
  - x=0.
  - On an edge with load=1: capture data_in into the payload shift register, load counter, x<=SYNC[SYNC_W-1], state->SYNC.
  - load while ready=0 is ignored and data_in is not sampled.
- SYNC:
  - x carries SYNC bits SYNC_W-1 down to 0, one per cycle.
  - After bit 0 has been on x for one cycle, x<=payload MSB and state->DATA.
- DATA:
  - x carries payload bits DATA_W-1 down to 0, one per cycle.
  - done=1 (registered, aligned with x) during the cycle bit 0 is on x.
  - Next edge: x<=0. If GAP_CYCLES>0, state->GAP; else state->IDLE.
- GAP: x=0 for exactly GAP_CYCLES cycles, then state->IDLE.
- Timing:
  - Capture edge = edge E. Sync bit k (MSB first) is on x in cycle E+1+k.
  - Payload bit j (MSB first) is on x in cycle E+1+SYNC_W+j.
  - ready is low from E+1 through E+SYNC_W+DATA_W+GAP_CYCLES and high again in the following cycle.
  - Minimum frame period = SYNC_W+DATA_W+GAP_CYCLES+1 cycles.
- Counter: a single down-counter sized $clog2(max(SYNC_W,DATA_W,GAP_CYCLES)+1), reloaded on each state change. No wrap: the terminal count forces the transition.
- Simultaneous events: rst low overrides load. load held high continuously starts a new frame on every IDLE cycle, i.e. back-to-back frames at the minimum period.
- Payload containing the sync pattern is transmitted unmodified. No bit-stuffing; false detection inside a payload is the receiver's concern.
- x is glitch-free (flop output); no combinational path from inputs to x, done or busy.

Test Plan:
- Reset, then load=1 with data_in=8'hA5 for one cycle -> x over the next 13 cycles = 1,0,0,1,1,1,0,1,0,0,1,0,1. done high only on the 13th. Then x=0 for 2 cycles; ready rises on cycle 16.
- Chain the output into the 10011 sequence detector (reset together) and send data_in=8'h00 -> detector z pulses exactly once, one cycle after the 5th frame bit. No z during payload or gap.
- Hold load=1 continuously with data_in=8'hFF, GAP_CYCLES=0 -> frames repeat every 14 cycles. Each frame is 1,0,0,1,1 then eight 1s, with one idle 0 cycle between frames.
- Pulse load while busy (cycle 4 of a frame) with data_in=8'h3C -> ignored: current frame completes unchanged, no second frame starts.
- Assert rst low during payload bit 3 -> x=0, busy=0, ready=1 immediately. After release, an idle line until the next load; a new frame with data_in=8'h01 transmits correctly from the first sync bit.
- Send data_in=8'b10011000 -> payload transmitted verbatim (x = 1,0,0,1,1,0,0,0 after sync). The detector reports z twice (sync and embedded pattern), confirming no stuffing.
